lpm_memory_pipe: RTL

//  Pipelined LPM lookup memory serving the Lpm engine's enter/recirc (req) and exit/recirc (resAccept) paths.

---
 rtl/lpm_pkg.sv | 20 ++
 rtl/lpm_table_ram.sv | 24 ++
 rtl/lpm_memory_pipe.sv | 108 ++++++++++
 3 files changed

// File: rtl/lpm_pkg.sv
// Shared LPM types and constants: request layout and lookup-pipe entry format.
package lpm_pkg;

   localparam int LPM_DATA_WIDTH = 704;
   localparam int LPM_PTR_LSB    = 0;
   localparam int LPM_PTR_W      = 32;
   localparam int LPM_LATENCY    = 3;
   localparam int LPM_AGE_W      = $clog2(LPM_LATENCY + 1);

   typedef struct packed {
      logic [LPM_DATA_WIDTH-1:LPM_PTR_W] rest;
      logic [LPM_PTR_W-1:0]              ptr;
   } lpm_req_t;

   typedef struct packed {
      lpm_req_t             payload;
      logic [LPM_AGE_W-1:0] age;
   } mem_entry_t;

endpackage

// File: rtl/lpm_table_ram.sv
// LPM pointer table: one asynchronous read port, one synchronous write port.
// Kept separate so an FPGA build can substitute a block RAM (needs LATENCY>=2).
module lpm_table_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              CLK,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // NOTE: table storage is deliberately not reset; software loads it before use.
   always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lpm_memory_pipe.sv
// Pipelined in-order LPM lookup: each request's pointer field is replaced by
// table[ptr] and the result is presented once it has aged LATENCY cycles.
module lpm_memory_pipe
   import lpm_pkg::*;
#(
   parameter int DATA_WIDTH = LPM_DATA_WIDTH,
   parameter int ADDR_W     = 8,
   parameter int DEPTH      = 4,
   parameter int LATENCY    = LPM_LATENCY
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  req__ENA,
   input  logic [DATA_WIDTH-1:0] req_v,
   output logic                  req__RDY,
   input  logic                  resAccept__ENA,
   output logic                  resAccept__RDY,
   output logic [DATA_WIDTH-1:0] resValue,
   output logic                  resValue__RDY,
   input  logic                  tbl_wr__ENA,
   input  logic [ADDR_W-1:0]     tbl_wr_addr,
   input  logic [31:0]           tbl_wr_data,
   output logic                  tbl_wr__RDY
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int AGE_W = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [AGE_W-1:0] AGE_INIT = AGE_W'(LATENCY - 1);

   logic [PTR_W-1:0]      wr_ptr, rd_ptr, offset;
   logic [CNT_W-1:0]      count;
   logic [DATA_WIDTH-1:0] payload_q [DEPTH];
   logic [AGE_W-1:0]      age_q [DEPTH];
   logic [DEPTH-1:0]      valid;
   logic [31:0]           tbl_rd_data;
   logic                  head_ready, consume, accept, tbl_wr_en;
   logic                  unused_ptr_hi;

   lpm_table_ram #(.ADDR_W(ADDR_W), .DATA_W(32)) u_table (
      .CLK     (CLK),
      .wr_en   (tbl_wr_en),
      .wr_addr (tbl_wr_addr),
      .wr_data (tbl_wr_data),
      .rd_addr (req_v[LPM_PTR_LSB +: ADDR_W]),
      .rd_data (tbl_rd_data)
   );

   // Pointer bits above the table index do not take part in the lookup.
   assign unused_ptr_hi = |req_v[LPM_PTR_W-1:ADDR_W];

   assign head_ready  = (count != '0) && (age_q[rd_ptr] == '0);
   assign consume     = resAccept__ENA && head_ready;
   // A same-cycle consume frees the slot, so a full pipe can still take a request.
   assign req__RDY    = (count < DEPTH_C) || consume;
   assign accept      = req__ENA && req__RDY;
   assign tbl_wr__RDY = (count == '0);
   assign tbl_wr_en   = tbl_wr__ENA && tbl_wr__RDY;

   assign resAccept__RDY = head_ready;
   assign resValue__RDY  = head_ready;
   assign resValue       = head_ready ? payload_q[rd_ptr] : '0;

   // NOTE: every variable gets a default before the loop so no latch is inferred.
   always_comb begin
      valid  = '0;
      offset = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset   = PTR_W'(i) - rd_ptr;
         valid[i] = CNT_W'(offset) < count;
      end
   end

   // NOTE: state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && age_q[i] != '0) age_q[i] <= age_q[i] - 1'b1;
         end
         if (accept) begin
            age_q[wr_ptr] <= AGE_INIT;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (consume) rd_ptr <= rd_ptr + 1'b1;
         case ({accept, consume})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Payload slots are qualified by count/age, so they need no reset.
   always_ff @(posedge CLK) begin
      if (!RST && accept)
         payload_q[wr_ptr] <= {req_v[DATA_WIDTH-1:LPM_PTR_W], tbl_rd_data};
   end

   a_req_legal : assert property (@(posedge CLK) disable iff (RST) req__ENA |-> req__RDY);
   a_acc_legal : assert property (@(posedge CLK) disable iff (RST) resAccept__ENA |-> resAccept__RDY);

endmodule
